eggtimer_ctrl: RTL
==================

// Module: eggtimer_ctrl
// PURPOSE
//  Run/pause/alarm sequencer for the egg timer. Holds the programmed mm:ss setpoint,
//  drives load/enable of the BCD digit_counter chain and restart of the 1 s clock_divider,
//  and raises the alarm when the countdown reaches 00:00. Sits between debounced buttons
//  and the timer datapath (clock_divider + digit_counter instances).
// PARAMETERS
//  ALARM_SECS  10  alarm duration in tick_1s pulses before auto-return to IDLE (1..15)
//  ASW         4   width of alarm tick counter; must hold ALARM_SECS
// PORTS
//  clk           in   1  system clock; single clock domain
//  reset         in   1  synchronous, active-high reset
//  start_stop    in   1  1-cycle debounced pulse: start / pause / resume
//  clear         in   1  1-cycle pulse: abort to IDLE, silence alarm
//  inc_min       in   1  1-cycle pulse: setpoint minutes +1 (IDLE only)
//  inc_sec       in   1  1-cycle pulse: setpoint seconds +1 (IDLE only)
//  tick_1s       in   1  1-cycle pulse from clock_divider
//  time_zero     in   1  high when all digit counters read 0
//  load          out  1  counters reload start_count from setpoint
//  count_en      out  1  enable to seconds digit_counter (one decrement)
//  div_clear     out  1  registered 1-cycle reset to clock_divider
//  alarm         out  1  alarm active
//  running       out  1  state == RUN
//  prog_min_t    out  4  setpoint minutes tens (BCD 0..5)
//  prog_min_o    out  4  setpoint minutes ones (BCD 0..9)
//  prog_sec_t    out  4  setpoint seconds tens (BCD 0..5)
//  prog_sec_o    out  4  setpoint seconds ones (BCD 0..9)
// BEHAVIOUR
//  States: IDLE, RUN, PAUSE, ALARM (2-bit). Reset -> IDLE, setpoint 00:00, div_clear=0,
//   alarm tick count 0; hence load=1, count_en=0, alarm=0, running=0 out of reset.
//  Priority per cycle: reset > clear > start_stop > inc_*.
//  IDLE: load=1 continuously. inc_min / inc_sec: BCD +1 of that pair, 59->00 wrap, no
//   carry between pairs; both same cycle -> both update. start_stop with setpoint != 00:00
//   -> RUN, div_clear=1 next cycle; with setpoint 00:00 -> ignored.
//  RUN: count_en = tick_1s (combinational, this state only). time_zero=1 -> ALARM next
//   cycle. start_stop -> PAUSE; a tick in that same cycle still counts. clear -> IDLE.
//  PAUSE: count_en=0; counters hold. start_stop -> RUN with div_clear pulse (partial second
//   discarded). clear -> IDLE. inc_* ignored.
//  ALARM: alarm=1; counter increments per tick_1s; at ALARM_SECS -> IDLE. clear or
//   start_stop -> IDLE at once. Entering IDLE reloads counters, setpoint kept.
//  inc_* outside IDLE: ignored. clear in IDLE: no effect (setpoint kept).
//  load, count_en, alarm, running: combinational from state; div_clear registered.
//  Setpoint 00:00 never enters RUN, so alarm requires a real countdown.
// STRUCTURE
//  eggtimer_pkg: state encodings (ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_ALARM=3), BCD_TENS_MAX=5,
//   BCD_ONES_MAX=9.
//  Sub-module bcd60_inc: 2-digit BCD +1 with 59->00 wrap; instantiated for minutes, seconds.
//  Top: state register + next-state logic, setpoint registers, alarm tick counter.
// TESTING
//  1. reset; inc_sec x3, inc_min x1 -> prog 01:03, load=1, count_en=0, running=0.
//  2. inc_sec x60 from 00 -> sec 59 after 59 pulses, 00 after 60; minutes unchanged.
//  3. setpoint 00:02, start_stop -> RUN, div_clear 1 cycle; ticks reach count_en; after
//     time_zero -> alarm=1; 10 ticks -> IDLE, load=1, setpoint still 00:02.
//  4. RUN, start_stop -> PAUSE: ticks give count_en=0; start_stop -> RUN with div_clear=1.
//  5. setpoint 00:00, start_stop -> stays IDLE; RUN + clear and start_stop same cycle -> IDLE.
//  6. reset asserted in ALARM and in PAUSE -> next cycle IDLE, prog 00:00, alarm=0.

Source files
------------

// File: rtl/eggtimer_pkg.sv
// Shared types and constants for the egg timer control slice.
// State encodings and BCD digit limits.
package eggtimer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_ONES_MAX = 4'd9;

endpackage

// File: rtl/bcd60_inc.sv
// Two-digit BCD increment, 59 wraps to 00.
// Purely combinational; used for the minutes and seconds setpoint.
module bcd60_inc
    import eggtimer_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] tens_nxt,
    output logic [3:0] ones_nxt
);

    always_comb begin
        tens_nxt = tens;
        ones_nxt = ones + 4'd1;
        if (ones >= BCD_ONES_MAX) begin
            ones_nxt = 4'd0;
            if (tens >= BCD_TENS_MAX) begin
                tens_nxt = 4'd0;
            end else begin
                tens_nxt = tens + 4'd1;
            end
        end
    end

endmodule

// File: rtl/eggtimer_ctrl.sv
// Run/pause/alarm sequencer for the egg timer.
// Owns the mm:ss setpoint and steers the divider and digit counters.
module eggtimer_ctrl
    import eggtimer_pkg::*;
#(
    parameter int ALARM_SECS = 10,
    parameter int ASW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       tick_1s,
    input  logic       time_zero,
    output logic       load,
    output logic       count_en,
    output logic       div_clear,
    output logic       alarm,
    output logic       running,
    output logic [3:0] prog_min_t,
    output logic [3:0] prog_min_o,
    output logic [3:0] prog_sec_t,
    output logic [3:0] prog_sec_o
);

    state_t state_q;
    state_t state_d;

    logic [3:0] min_t_q;
    logic [3:0] min_o_q;
    logic [3:0] sec_t_q;
    logic [3:0] sec_o_q;
    logic [3:0] min_t_nxt;
    logic [3:0] min_o_nxt;
    logic [3:0] sec_t_nxt;
    logic [3:0] sec_o_nxt;

    logic [ASW-1:0] alarm_cnt_q;
    logic           div_clear_q;
    logic           setpt_zero;
    logic           alarm_done;
    logic           edit_en;

    assign setpt_zero = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                        (sec_t_q == 4'd0) && (sec_o_q == 4'd0);

    assign alarm_done = tick_1s &&
                        (alarm_cnt_q == ASW'(ALARM_SECS - 1));

    // clear and start_stop both outrank setpoint edits
    assign edit_en = (state_q == ST_IDLE) && !clear && !start_stop;

    bcd60_inc u_min_inc (
        .tens     (min_t_q),
        .ones     (min_o_q),
        .tens_nxt (min_t_nxt),
        .ones_nxt (min_o_nxt)
    );

    bcd60_inc u_sec_inc (
        .tens     (sec_t_q),
        .ones     (sec_o_q),
        .tens_nxt (sec_t_nxt),
        .ones_nxt (sec_o_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!clear && start_stop && !setpt_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (time_zero) begin
                    state_d = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (clear || start_stop || alarm_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        count_en = 1'b0;
        alarm    = 1'b0;
        running  = 1'b0;
        unique case (state_q)
            ST_IDLE:  load = 1'b1;
            ST_RUN: begin
                running  = 1'b1;
                count_en = tick_1s;
            end
            ST_PAUSE: ;
            ST_ALARM: alarm = 1'b1;
            default:  load = 1'b1;
        endcase
    end

    // any entry into RUN restarts the divider so a fresh full second begins
    always_ff @(posedge clk) begin
        if (reset) begin
            div_clear_q <= 1'b0;
        end else begin
            div_clear_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_cnt_q <= '0;
        end else if (state_q != ST_ALARM) begin
            alarm_cnt_q <= '0;
        end else if (tick_1s) begin
            alarm_cnt_q <= alarm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_t_q <= 4'd0;
            min_o_q <= 4'd0;
            sec_t_q <= 4'd0;
            sec_o_q <= 4'd0;
        end else if (edit_en) begin
            if (inc_min) begin
                min_t_q <= min_t_nxt;
                min_o_q <= min_o_nxt;
            end
            if (inc_sec) begin
                sec_t_q <= sec_t_nxt;
                sec_o_q <= sec_o_nxt;
            end
        end
    end

    assign div_clear  = div_clear_q;
    assign prog_min_t = min_t_q;
    assign prog_min_o = min_o_q;
    assign prog_sec_t = sec_t_q;
    assign prog_sec_o = sec_o_q;

endmodule
